// File: rtl/up_reg_bank_if.sv
// up_* microprocessor bus between the USB-SPI master and the register bank.
// The master drives address, strobes and write data; the bank returns
// registered read data.
interface up_reg_bank_if;
  logic [31:0] up_addr;
  logic        up_wr;
  logic        up_rd;
  logic [31:0] up_wr_data;
  logic [31:0] up_rd_data;

  modport master (
    output up_addr,
    output up_wr,
    output up_rd,
    output up_wr_data,
    input  up_rd_data
  );

  modport slave (
    input  up_addr,
    input  up_wr,
    input  up_rd,
    input  up_wr_data,
    output up_rd_data
  );
endinterface

// File: rtl/up_reg_bank.sv
// up_reg_bank: tester register bank on the up_* bus.
// Holds VERSION/SCRATCH/CTRL, command pulses, interrupt status and mask,
// two 64-bit event counters with hi-word snapshot, and a synchronized
// status vector. Read data is registered (latency 1).
// Build option: define UP_REG_BANK_CNT_SAT_EN to make the TX/RX counters
// saturate at all-ones instead of wrapping to zero.
module up_reg_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] VERSION   = 32'h2014_0102,
  parameter int          STATUS_W  = 16
) (
  input  logic                up_clk,
  input  logic                up_rst_n,
  up_reg_bank_if.slave        up,
  output logic [31:0]         ctrl_o,
  output logic [7:0]          cmd_pulse_o,
  input  logic [7:0]          evt_i,
  output logic                irq_o,
  input  logic                tx_inc_i,
  input  logic                rx_inc_i,
  input  logic [STATUS_W-1:0] status_i
);

  localparam logic [7:0] OFF_VERSION = 8'h00;
  localparam logic [7:0] OFF_SCRATCH = 8'h01;
  localparam logic [7:0] OFF_CTRL    = 8'h02;
  localparam logic [7:0] OFF_CMD     = 8'h03;
  localparam logic [7:0] OFF_IRQ_ST  = 8'h04;
  localparam logic [7:0] OFF_IRQ_MSK = 8'h05;
  localparam logic [7:0] OFF_TX_LO   = 8'h06;
  localparam logic [7:0] OFF_TX_HI   = 8'h07;
  localparam logic [7:0] OFF_RX_LO   = 8'h08;
  localparam logic [7:0] OFF_RX_HI   = 8'h09;
  localparam logic [7:0] OFF_STATUS  = 8'h0A;

  // One counter step; saturating or wrapping depending on the build.
  function automatic logic [63:0] cnt_step(input logic [63:0] c);
`ifdef UP_REG_BANK_CNT_SAT_EN
    cnt_step = (&c) ? c : c + 64'd1;
`else
    cnt_step = c + 64'd1;
`endif
  endfunction

  logic          hit;
  logic [7:0]    offset;
  logic          wr_hit;
  logic          rd_hit;
  logic          cnt_clr;
  logic          tx_snap;
  logic          rx_snap;
  logic          stat_w1c;

  logic [31:0]   scratch;
  logic [31:0]   ctrl;
  logic [7:0]    cmd_pulse;
  logic [7:0]    irq_stat;
  logic [7:0]    irq_stat_next;
  logic [7:0]    irq_mask;
  logic          irq;
  logic [63:0]   cnt_tx;
  logic [63:0]   cnt_rx;
  logic [31:0]   tx_shadow;
  logic [31:0]   rx_shadow;
  logic [STATUS_W-1:0] status_meta;
  logic [STATUS_W-1:0] status_sync;
  logic [31:0]   status_ext;
  logic [31:0]   rd_mux;
  logic [31:0]   rd_data;

  assign hit      = (up.up_addr[31:8] == BASE_ADDR[31:8]);
  assign offset   = up.up_addr[7:0];
  assign wr_hit   = up.up_wr & hit;
  assign rd_hit   = up.up_rd & hit;
  assign cnt_clr  = wr_hit && (offset == OFF_CMD) && up.up_wr_data[0];
  assign tx_snap  = rd_hit && (offset == OFF_TX_LO);
  assign rx_snap  = rd_hit && (offset == OFF_RX_LO);
  assign stat_w1c = wr_hit && (offset == OFF_IRQ_ST);

  // Per-bit status next state: a new event beats a coincident W1C.
  // Status vector zero-extended to the 32-bit read width.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_irq_bit
      assign irq_stat_next[gi] = evt_i[gi] |
                                 (irq_stat[gi] & ~(stat_w1c & up.up_wr_data[gi]));
    end
    for (genvar gi = 0; gi < 32; gi++) begin : g_status_ext
      if (gi < STATUS_W) begin : g_bit
        assign status_ext[gi] = status_sync[gi];
      end else begin : g_zero
        assign status_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Software-writable registers and the one-cycle command pulses.
  always_ff @(posedge up_clk or negedge up_rst_n) begin
    if (!up_rst_n) begin
      scratch   <= '0;
      ctrl      <= '0;
      irq_mask  <= '0;
      cmd_pulse <= '0;
    end else begin
      cmd_pulse <= (wr_hit && offset == OFF_CMD) ? up.up_wr_data[7:0] : 8'h00;
      if (wr_hit && offset == OFF_SCRATCH) scratch  <= up.up_wr_data;
      if (wr_hit && offset == OFF_CTRL)    ctrl     <= up.up_wr_data;
      if (wr_hit && offset == OFF_IRQ_MSK) irq_mask <= up.up_wr_data[7:0];
    end
  end

  // Interrupt status register and the registered interrupt output.
  always_ff @(posedge up_clk or negedge up_rst_n) begin
    if (!up_rst_n) begin
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      irq_stat <= irq_stat_next;
      irq      <= |(irq_stat & irq_mask);
    end
  end

  // TX counter and its hi-word snapshot taken on a LO read.
  always_ff @(posedge up_clk or negedge up_rst_n) begin
    if (!up_rst_n) begin
      cnt_tx    <= '0;
      tx_shadow <= '0;
    end else begin
      if (cnt_clr)       cnt_tx <= '0;
      else if (tx_inc_i) cnt_tx <= cnt_step(cnt_tx);
      if (cnt_clr)       tx_shadow <= '0;
      else if (tx_snap)  tx_shadow <= cnt_tx[63:32];
    end
  end

  // RX counter and its hi-word snapshot taken on a LO read.
  always_ff @(posedge up_clk or negedge up_rst_n) begin
    if (!up_rst_n) begin
      cnt_rx    <= '0;
      rx_shadow <= '0;
    end else begin
      if (cnt_clr)       cnt_rx <= '0;
      else if (rx_inc_i) cnt_rx <= cnt_step(cnt_rx);
      if (cnt_clr)       rx_shadow <= '0;
      else if (rx_snap)  rx_shadow <= cnt_rx[63:32];
    end
  end

  // Two-flop synchronizer for the asynchronous status inputs.
  always_ff @(posedge up_clk or negedge up_rst_n) begin
    if (!up_rst_n) begin
      status_meta <= '0;
      status_sync <= '0;
    end else begin
      status_meta <= status_i;
      status_sync <= status_meta;
    end
  end

  // Read multiplexer; misses and unmapped offsets read as zero.
  always_comb begin
    rd_mux = 32'h0;
    if (hit) begin
      case (offset)
        OFF_VERSION: rd_mux = VERSION;
        OFF_SCRATCH: rd_mux = scratch;
        OFF_CTRL:    rd_mux = ctrl;
        OFF_IRQ_ST:  rd_mux = {24'h0, irq_stat};
        OFF_IRQ_MSK: rd_mux = {24'h0, irq_mask};
        OFF_TX_LO:   rd_mux = cnt_tx[31:0];
        OFF_TX_HI:   rd_mux = tx_shadow;
        OFF_RX_LO:   rd_mux = cnt_rx[31:0];
        OFF_RX_HI:   rd_mux = rx_shadow;
        OFF_STATUS:  rd_mux = status_ext;
        default:     rd_mux = 32'h0;
      endcase
    end
  end

  // Registered read data; holds between reads and sees pre-write values.
  always_ff @(posedge up_clk or negedge up_rst_n) begin
    if (!up_rst_n) rd_data <= '0;
    else if (up.up_rd) rd_data <= rd_mux;
  end

  assign up.up_rd_data = rd_data;
  assign ctrl_o        = ctrl;
  assign cmd_pulse_o   = cmd_pulse;
  assign irq_o         = irq;

endmodule

// File: tb/tb_up_reg_bank.sv
// Directed testbench for up_reg_bank: a table of single-cycle bus vectors
// with hand-computed results, then hand-written counter snapshot and
// wrap/saturation sequences.
module tb_up_reg_bank;

  logic        up_clk;
  logic        up_rst_n;
  logic [7:0]  evt_i;
  logic        tx_inc_i;
  logic        rx_inc_i;
  logic [15:0] status_i;
  logic [31:0] ctrl_o;
  logic [7:0]  cmd_pulse_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  up_reg_bank_if bus ();

  up_reg_bank dut (
    .up_clk      (up_clk),
    .up_rst_n    (up_rst_n),
    .up          (bus),
    .ctrl_o      (ctrl_o),
    .cmd_pulse_o (cmd_pulse_o),
    .evt_i       (evt_i),
    .irq_o       (irq_o),
    .tx_inc_i    (tx_inc_i),
    .rx_inc_i    (rx_inc_i),
    .status_i    (status_i)
  );

  initial up_clk = 1'b0;
  always #5 up_clk = ~up_clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  evt;
    logic        tx;
    logic        rx;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic [7:0]  exp_cmd;
    logic [31:0] exp_ctrl;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [7:0] evt,
                              input logic tx, input logic rx, input logic [31:0] exp_rd,
                              input logic exp_irq, input logic [7:0] exp_cmd,
                              input logic [31:0] exp_ctrl);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.evt = evt;
    v.tx = tx; v.rx = rx; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    v.exp_cmd = exp_cmd; v.exp_ctrl = exp_ctrl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic cyc(input logic wr, input logic rd, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [7:0] evt,
                     input logic tx, input logic rx);
    @(negedge up_clk);
    bus.up_wr      = wr;
    bus.up_rd      = rd;
    bus.up_addr    = addr;
    bus.up_wr_data = wdata;
    evt_i          = evt;
    tx_inc_i       = tx;
    rx_inc_i       = rx;
    @(posedge up_clk);
    #1;
  endtask

  logic [31:0] exp_wrap;

  initial begin
`ifdef UP_REG_BANK_CNT_SAT_EN
    exp_wrap = 32'hFFFF_FFFF;
`else
    exp_wrap = 32'h0000_0000;
`endif
    //                wr rd addr          wdata         evt    tx rx exp_rd        irq cmd    ctrl
    vecs[0]  = mk(0, 1, 32'h0000_0000, 32'h0,         8'h00, 0, 0, 32'h2014_0102, 0, 8'h00, 32'h0);
    vecs[1]  = mk(0, 1, 32'h0000_0001, 32'h0,         8'h00, 0, 0, 32'h0,         0, 8'h00, 32'h0);
    vecs[2]  = mk(0, 1, 32'h0000_0002, 32'h0,         8'h00, 0, 0, 32'h0,         0, 8'h00, 32'h0);
    vecs[3]  = mk(1, 0, 32'h0000_0001, 32'hA5A5_5A5A, 8'h00, 0, 0, 32'h0,         0, 8'h00, 32'h0);
    vecs[4]  = mk(0, 1, 32'h0000_0001, 32'h0,         8'h00, 0, 0, 32'hA5A5_5A5A, 0, 8'h00, 32'h0);
    vecs[5]  = mk(1, 0, 32'h0000_0101, 32'h1234_5678, 8'h00, 0, 0, 32'hA5A5_5A5A, 0, 8'h00, 32'h0);
    vecs[6]  = mk(0, 1, 32'h0000_0101, 32'h0,         8'h00, 0, 0, 32'h0,         0, 8'h00, 32'h0);
    vecs[7]  = mk(0, 1, 32'h0000_0001, 32'h0,         8'h00, 0, 0, 32'hA5A5_5A5A, 0, 8'h00, 32'h0);
    vecs[8]  = mk(1, 0, 32'h0000_0002, 32'hCAFE_0001, 8'h00, 0, 0, 32'hA5A5_5A5A, 0, 8'h00, 32'hCAFE_0001);
    vecs[9]  = mk(1, 1, 32'h0000_0002, 32'h0000_00FF, 8'h00, 0, 0, 32'hCAFE_0001, 0, 8'h00, 32'h0000_00FF);
    vecs[10] = mk(0, 1, 32'h0000_000A, 32'h0,         8'h00, 0, 0, 32'h0000_BEEF, 0, 8'h00, 32'h0000_00FF);
    vecs[11] = mk(0, 0, 32'h0000_0000, 32'h0,         8'h00, 1, 1, 32'h0000_BEEF, 0, 8'h00, 32'h0000_00FF);
    vecs[12] = mk(0, 0, 32'h0000_0000, 32'h0,         8'h00, 1, 0, 32'h0000_BEEF, 0, 8'h00, 32'h0000_00FF);
    vecs[13] = mk(0, 1, 32'h0000_0006, 32'h0,         8'h00, 0, 0, 32'h0000_0002, 0, 8'h00, 32'h0000_00FF);
    vecs[14] = mk(0, 1, 32'h0000_0008, 32'h0,         8'h00, 0, 0, 32'h0000_0001, 0, 8'h00, 32'h0000_00FF);
    vecs[15] = mk(1, 0, 32'h0000_0003, 32'h0000_0081, 8'h00, 0, 0, 32'h0000_0001, 0, 8'h81, 32'h0000_00FF);
    vecs[16] = mk(0, 0, 32'h0000_0000, 32'h0,         8'h00, 0, 0, 32'h0000_0001, 0, 8'h00, 32'h0000_00FF);
    vecs[17] = mk(0, 1, 32'h0000_0003, 32'h0,         8'h00, 0, 0, 32'h0,         0, 8'h00, 32'h0000_00FF);
    vecs[18] = mk(0, 1, 32'h0000_0006, 32'h0,         8'h00, 0, 0, 32'h0,         0, 8'h00, 32'h0000_00FF);
    vecs[19] = mk(0, 0, 32'h0000_0000, 32'h0,         8'h04, 0, 0, 32'h0,         0, 8'h00, 32'h0000_00FF);
    vecs[20] = mk(1, 0, 32'h0000_0005, 32'hFFFF_FF04, 8'h00, 0, 0, 32'h0,         0, 8'h00, 32'h0000_00FF);
    vecs[21] = mk(0, 1, 32'h0000_0005, 32'h0,         8'h00, 0, 0, 32'h0000_0004, 1, 8'h00, 32'h0000_00FF);
    vecs[22] = mk(0, 1, 32'h0000_0004, 32'h0,         8'h00, 0, 0, 32'h0000_0004, 1, 8'h00, 32'h0000_00FF);
    vecs[23] = mk(1, 0, 32'h0000_0004, 32'h0000_0004, 8'h04, 0, 0, 32'h0000_0004, 1, 8'h00, 32'h0000_00FF);
    vecs[24] = mk(0, 1, 32'h0000_0004, 32'h0,         8'h00, 0, 0, 32'h0000_0004, 1, 8'h00, 32'h0000_00FF);
    vecs[25] = mk(1, 0, 32'h0000_0004, 32'h0000_0004, 8'h00, 0, 0, 32'h0000_0004, 1, 8'h00, 32'h0000_00FF);
    vecs[26] = mk(0, 0, 32'h0000_0000, 32'h0,         8'h00, 0, 0, 32'h0000_0004, 0, 8'h00, 32'h0000_00FF);
    vecs[27] = mk(0, 1, 32'h0000_0004, 32'h0,         8'h00, 0, 0, 32'h0,         0, 8'h00, 32'h0000_00FF);
    vecs[28] = mk(1, 0, 32'h0000_0000, 32'hFFFF_FFFF, 8'h00, 0, 0, 32'h0,         0, 8'h00, 32'h0000_00FF);
    vecs[29] = mk(0, 1, 32'h0000_0000, 32'h0,         8'h00, 0, 0, 32'h2014_0102, 0, 8'h00, 32'h0000_00FF);
    vecs[30] = mk(0, 1, 32'h0000_000B, 32'h0,         8'h00, 0, 0, 32'h0,         0, 8'h00, 32'h0000_00FF);
    vecs[31] = mk(0, 1, 32'h0000_0004, 32'h0,         8'h80, 0, 0, 32'h0,         0, 8'h00, 32'h0000_00FF);
    vecs[32] = mk(0, 1, 32'h0000_0004, 32'h0,         8'h00, 0, 0, 32'h0000_0080, 0, 8'h00, 32'h0000_00FF);

    // Reset state.
    up_rst_n       = 1'b0;
    bus.up_wr      = 1'b0;
    bus.up_rd      = 1'b0;
    bus.up_addr    = 32'h0;
    bus.up_wr_data = 32'h0;
    evt_i          = 8'h00;
    tx_inc_i       = 1'b0;
    rx_inc_i       = 1'b0;
    status_i       = 16'hBEEF;
    repeat (3) @(posedge up_clk);
    #1;
    chk("reset_rd_data", bus.up_rd_data, 32'h0);
    chk("reset_ctrl",    ctrl_o, 32'h0);
    chk("reset_cmd",     {24'h0, cmd_pulse_o}, 32'h0);
    chk("reset_irq",     {31'h0, irq_o}, 32'h0);
    @(negedge up_clk);
    up_rst_n = 1'b1;

    // Table-driven bus vectors.
    for (int i = 0; i < NVEC; i++) begin
      cyc(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].evt,
          vecs[i].tx, vecs[i].rx);
      chk($sformatf("v%0d_rd_data", i), bus.up_rd_data, vecs[i].exp_rd);
      chk($sformatf("v%0d_irq", i),     {31'h0, irq_o}, {31'h0, vecs[i].exp_irq});
      chk($sformatf("v%0d_cmd", i),     {24'h0, cmd_pulse_o}, {24'h0, vecs[i].exp_cmd});
      chk($sformatf("v%0d_ctrl", i),    ctrl_o, vecs[i].exp_ctrl);
      $display("vec %0d wr=%0b rd=%0b addr=%h wdata=%h rd_data=%h irq=%0b cmd=%h",
               i, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
               bus.up_rd_data, irq_o, cmd_pulse_o);
    end

    // Hi-word snapshot: LO read freezes the hi word while the counter moves on.
    @(negedge up_clk);
    force dut.cnt_tx = 64'h0000_0000_FFFF_FFFF;
    @(negedge up_clk);
    release dut.cnt_tx;
    cyc(0, 1, 32'h0000_0006, 32'h0, 8'h00, 1, 0);
    chk("snap_lo", bus.up_rd_data, 32'hFFFF_FFFF);
    cyc(0, 0, 32'h0000_0000, 32'h0, 8'h00, 1, 0);
    cyc(0, 1, 32'h0000_0007, 32'h0, 8'h00, 1, 0);
    chk("snap_hi", bus.up_rd_data, 32'h0);
    cyc(0, 1, 32'h0000_0006, 32'h0, 8'h00, 0, 0);
    chk("snap_lo2", bus.up_rd_data, 32'h0000_0002);
    cyc(0, 1, 32'h0000_0007, 32'h0, 8'h00, 0, 0);
    chk("snap_hi2", bus.up_rd_data, 32'h0000_0001);
    $display("seq snapshot done rd_data=%h", bus.up_rd_data);

    // All-ones counter plus one increment: wraps or saturates per build.
    @(negedge up_clk);
    bus.up_rd = 1'b0;
    force dut.cnt_tx = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge up_clk);
    release dut.cnt_tx;
    cyc(0, 0, 32'h0000_0000, 32'h0, 8'h00, 1, 0);
    cyc(0, 1, 32'h0000_0006, 32'h0, 8'h00, 0, 0);
    chk("wrap_lo", bus.up_rd_data, exp_wrap);
    cyc(0, 1, 32'h0000_0007, 32'h0, 8'h00, 0, 0);
    chk("wrap_hi", bus.up_rd_data, exp_wrap);
    $display("seq wrap done rd_data=%h", bus.up_rd_data);

    // Clear coincident with increment leaves the counter at zero.
    cyc(1, 0, 32'h0000_0003, 32'h0000_0001, 8'h00, 1, 1);
    chk("clr_cmd", {24'h0, cmd_pulse_o}, 32'h0000_0001);
    cyc(0, 1, 32'h0000_0006, 32'h0, 8'h00, 0, 0);
    chk("clr_tx_lo", bus.up_rd_data, 32'h0);
    chk("clr_cmd_end", {24'h0, cmd_pulse_o}, 32'h0);
    cyc(0, 1, 32'h0000_0008, 32'h0, 8'h00, 0, 0);
    chk("clr_rx_lo", bus.up_rd_data, 32'h0);
    $display("seq clear done rd_data=%h", bus.up_rd_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
